// File: rtl/muldiv_sequencer_pkg.sv
// Shared encodings for the multiply/divide sequencer: op codes, FSM states and default widths.
package muldiv_sequencer_pkg;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int OP_WIDTH_DEF   = 3;
  localparam int CNT_WIDTH_DEF  = 6;

  localparam int OP_MULT  = 0;
  localparam int OP_MULTU = 1;
  localparam int OP_DIV   = 2;
  localparam int OP_DIVU  = 3;
  localparam int OP_MTHI  = 4;
  localparam int OP_MTLO  = 5;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_FINISH = 2'd2;

endpackage

// File: rtl/muldiv_signfix.sv
// Conditional two's-complement negate; used as abs() on operands and as sign fixup on results.
module muldiv_signfix
  import muldiv_sequencer_pkg::*;
#(
  parameter int WIDTH = 2 * DATA_WIDTH_DEF
) (
  input  logic [WIDTH-1:0] value,
  input  logic             negate,
  output logic [WIDTH-1:0] result
);

  assign result = negate ? (~value + WIDTH'(1)) : value;

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative shift-add multiply / restoring divide unit owning the HI/LO pair.
module muldiv_sequencer
  import muldiv_sequencer_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int OP_WIDTH   = OP_WIDTH_DEF,
  parameter int CNT_WIDTH  = CNT_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_in,
  input  logic [OP_WIDTH-1:0]   op_in,
  input  logic [DATA_WIDTH-1:0] rs_data_in,
  input  logic [DATA_WIDTH-1:0] rt_data_in,
  input  logic                  abort_in,
  output logic [DATA_WIDTH-1:0] hi_out,
  output logic [DATA_WIDTH-1:0] lo_out,
  output logic                  busy_out,
  output logic                  done_out
);

  localparam int W = DATA_WIDTH;

  logic [1:0]           state_reg;
  logic [CNT_WIDTH-1:0] cnt_reg;
  logic [2*W-1:0]       acc_reg;
  logic [W-1:0]         opnd_reg;
  logic [W-1:0]         rs_orig_reg;
  logic [W-1:0]         hi_reg, lo_reg;
  logic                 is_div_reg, sign_diff_reg, rem_neg_reg, div_zero_reg, done_reg;

  logic op_mul, op_div, op_signed;
  assign op_mul    = (op_in == OP_WIDTH'(OP_MULT)) || (op_in == OP_WIDTH'(OP_MULTU));
  assign op_div    = (op_in == OP_WIDTH'(OP_DIV))  || (op_in == OP_WIDTH'(OP_DIVU));
  assign op_signed = (op_in == OP_WIDTH'(OP_MULT)) || (op_in == OP_WIDTH'(OP_DIV));

  // Operand conditioning: index 0 is rs, index 1 is rt.
  logic [W-1:0] src_raw [2];
  logic [W-1:0] src_mag [2];
  logic         src_neg [2];
  assign src_raw[0] = rs_data_in;
  assign src_raw[1] = rt_data_in;

  for (genvar gi = 0; gi < 2; gi++) begin : g_cond
    assign src_neg[gi] = op_signed & src_raw[gi][W-1];
    muldiv_signfix #(.WIDTH(W)) u_abs (
      .value  (src_raw[gi]),
      .negate (src_neg[gi]),
      .result (src_mag[gi])
    );
  end

  // Multiply step: carry out of the upper-half add shifts back in at the top.
  logic [W:0]     mul_sum;
  logic [2*W-1:0] mul_next;
  assign mul_sum  = {1'b0, acc_reg[2*W-1:W]} + {1'b0, opnd_reg};
  assign mul_next = acc_reg[0] ? {mul_sum, acc_reg[W-1:1]} : {1'b0, acc_reg[2*W-1:1]};

  // Divide step: the shifted partial remainder is W+1 bits, so trial in W+2 bits.
  logic [W+1:0]   div_trial;
  logic           div_ok;
  logic [2*W-1:0] div_next;
  assign div_trial = {1'b0, acc_reg[2*W-1:W-1]} - {2'b00, opnd_reg};
  assign div_ok    = (div_trial[W+1:W] == 2'b00);
  assign div_next  = {div_ok ? div_trial[W-1:0] : acc_reg[2*W-2:W-1], acc_reg[W-2:0], div_ok};

  logic [2*W-1:0] prod_res;
  logic [W-1:0]   quot_res, rem_res;
  muldiv_signfix #(.WIDTH(2*W)) u_prod_fix (
    .value (acc_reg), .negate (sign_diff_reg), .result (prod_res)
  );
  muldiv_signfix #(.WIDTH(W)) u_quot_fix (
    .value (acc_reg[W-1:0]), .negate (sign_diff_reg), .result (quot_res)
  );
  muldiv_signfix #(.WIDTH(W)) u_rem_fix (
    .value (acc_reg[2*W-1:W]), .negate (rem_neg_reg), .result (rem_res)
  );

  // Divide by zero reports the dividend exactly as issued, not its magnitude.
  logic [W-1:0] hi_fin, lo_fin;
  assign hi_fin = is_div_reg ? (div_zero_reg ? rs_orig_reg : rem_res)  : prod_res[2*W-1:W];
  assign lo_fin = is_div_reg ? (div_zero_reg ? '1          : quot_res) : prod_res[W-1:0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      cnt_reg       <= '0;
      acc_reg       <= '0;
      opnd_reg      <= '0;
      rs_orig_reg   <= '0;
      hi_reg        <= '0;
      lo_reg        <= '0;
      is_div_reg    <= 1'b0;
      sign_diff_reg <= 1'b0;
      rem_neg_reg   <= 1'b0;
      div_zero_reg  <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (start_in) begin
            if (op_mul || op_div) begin
              state_reg     <= ST_RUN;
              cnt_reg       <= '0;
              is_div_reg    <= op_div;
              acc_reg       <= {{W{1'b0}}, op_div ? src_mag[0] : src_mag[1]};
              opnd_reg      <= op_div ? src_mag[1] : src_mag[0];
              sign_diff_reg <= src_neg[0] ^ src_neg[1];
              rem_neg_reg   <= src_neg[0];
              div_zero_reg  <= op_div && (rt_data_in == '0);
              rs_orig_reg   <= rs_data_in;
            end else if (op_in == OP_WIDTH'(OP_MTHI)) begin
              hi_reg <= rs_data_in;
            end else if (op_in == OP_WIDTH'(OP_MTLO)) begin
              lo_reg <= rs_data_in;
            end
          end
        end
        ST_RUN: begin
          if (abort_in) begin
            state_reg <= ST_IDLE;
          end else begin
            acc_reg <= is_div_reg ? div_next : mul_next;
            cnt_reg <= cnt_reg + CNT_WIDTH'(1);
            if (cnt_reg == CNT_WIDTH'(W-1)) state_reg <= ST_FINISH;
          end
        end
        ST_FINISH: begin
          state_reg <= ST_IDLE;
          if (!abort_in) begin
            hi_reg   <= hi_fin;
            lo_reg   <= lo_fin;
            done_reg <= 1'b1;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign hi_out   = hi_reg;
  assign lo_out   = lo_reg;
  assign busy_out = (state_reg != ST_IDLE);
  assign done_out = done_reg;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench: transaction-level reference model compared every cycle, plus literal pins.
module tb_muldiv_sequencer;

  localparam logic [2:0] MULT = 3'd0, MULTU = 3'd1, DIV = 3'd2, DIVU = 3'd3, MTHI = 3'd4, MTLO = 3'd5;
  localparam int LAT = 33;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_in = 1'b0;
  logic [2:0]  op_in = 3'd0;
  logic [31:0] rs_data_in = '0;
  logic [31:0] rt_data_in = '0;
  logic        abort_in = 1'b0;
  logic [31:0] hi_out, lo_out;
  logic        busy_out, done_out;

  always #5 clk = ~clk;

  muldiv_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_in   (start_in),
    .op_in      (op_in),
    .rs_data_in (rs_data_in),
    .rt_data_in (rt_data_in),
    .abort_in   (abort_in),
    .hi_out     (hi_out),
    .lo_out     (lo_out),
    .busy_out   (busy_out),
    .done_out   (done_out)
  );

  int checks = 0;
  int errors = 0;
  bit check_en = 1'b0;

  // Reference model state: an op in flight is just a countdown plus its precomputed result.
  bit          m_busy = 1'b0;
  bit          m_done = 1'b0;
  int          m_left = 0;
  logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;

  function automatic void ref_result(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                     output logic [31:0] hi, output logic [31:0] lo);
    longint sa, sb, q, r;
    longint unsigned ua, ub, uq, ur;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    hi = '0;
    lo = '0;
    case (op)
      MULT:  begin q = sa * sb; hi = q[63:32]; lo = q[31:0]; end
      MULTU: begin uq = ua * ub; hi = uq[63:32]; lo = uq[31:0]; end
      DIV: begin
        if (b == 0) begin hi = a; lo = '1; end
        else begin q = sa / sb; r = sa % sb; hi = r[31:0]; lo = q[31:0]; end
      end
      DIVU: begin
        if (b == 0) begin hi = a; lo = '1; end
        else begin uq = ua / ub; ur = ua % ub; hi = ur[31:0]; lo = uq[31:0]; end
      end
      default: ;
    endcase
  endfunction

  always @(posedge clk) begin
    m_done = 1'b0;
    if (!rst_n) begin
      m_busy = 1'b0;
      m_hi = '0;
      m_lo = '0;
    end else if (m_busy) begin
      if (abort_in) m_busy = 1'b0;
      else if (m_left == 0) begin
        m_hi = p_hi;
        m_lo = p_lo;
        m_done = 1'b1;
        m_busy = 1'b0;
      end else m_left--;
    end else if (start_in) begin
      if (op_in <= DIVU) begin
        ref_result(op_in, rs_data_in, rt_data_in, p_hi, p_lo);
        m_busy = 1'b1;
        m_left = LAT - 1;
        $display("txn t=%0t op=%0d rs=%h rt=%h expect hi=%h lo=%h", $time, op_in, rs_data_in, rt_data_in, p_hi, p_lo);
      end else if (op_in == MTHI) begin
        m_hi = rs_data_in;
        $display("txn t=%0t MTHI rs=%h", $time, rs_data_in);
      end else if (op_in == MTLO) begin
        m_lo = rs_data_in;
        $display("txn t=%0t MTLO rs=%h", $time, rs_data_in);
      end
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      checks++;
      if ({hi_out, lo_out, busy_out, done_out} !== {m_hi, m_lo, m_busy, m_done}) begin
        errors++;
        $display("FAIL cycle_compare t=%0t actual hi=%h lo=%h busy=%b done=%b required hi=%h lo=%h busy=%b done=%b",
                 $time, hi_out, lo_out, busy_out, done_out, m_hi, m_lo, m_busy, m_done);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    start_in = 1'b1;
    op_in = op;
    rs_data_in = a;
    rt_data_in = b;
    step();
    start_in = 1'b0;
  endtask

  task automatic wait_done(output int lat, output int busy_cnt);
    lat = 0;
    busy_cnt = 0;
    while (!done_out && lat < 100) begin
      if (busy_out) busy_cnt++;
      step();
      lat++;
    end
    if (!done_out) begin
      checks++;
      errors++;
      $display("FAIL done_timeout actual=no done required=done within 100 cycles");
    end
  endtask

  task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int lat, bc;
    issue(op, a, b);
    wait_done(lat, bc);
    check({name, "_latency"}, lat, LAT);
    check({name, "_busy_cycles"}, bc, LAT);
    check({name, "_hi"}, hi_out, exp_hi);
    check({name, "_lo"}, lo_out, exp_lo);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat, bc;
    logic [31:0] save_hi, save_lo;

    step();
    step();
    check_en = 1'b1;
    check("reset_hi", hi_out, 32'h0);
    check("reset_lo", lo_out, 32'h0);
    check("reset_busy", {31'd0, busy_out}, 32'h0);
    check("reset_done", {31'd0, done_out}, 32'h0);
    rst_n = 1'b1;
    step();

    run_op("mult_7_m3",    MULT,  32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    run_op("divu_100_7",   DIVU,  32'd100,        32'd7,         32'd2,         32'd14);
    run_op("div_m7_2",     DIV,   32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("div_by_zero",  DIV,   32'h1234_5678,  32'd0,         32'h1234_5678, 32'hFFFF_FFFF);
    run_op("div_intmin",   DIV,   32'h8000_0000,  32'hFFFF_FFFF, 32'h0,         32'h8000_0000);
    run_op("multu_ones",   MULTU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);

    issue(MTHI, 32'hA5A5_A5A5, 32'h0);
    check("mthi_hi", hi_out, 32'hA5A5_A5A5);
    check("mthi_busy", {31'd0, busy_out}, 32'h0);

    // Start and MTLO while busy must be dropped.
    issue(MULTU, 32'd9, 32'd9);
    repeat (3) step();
    issue(MULTU, 32'd2, 32'd3);
    issue(MTLO, 32'hDEAD_BEEF, 32'h0);
    wait_done(lat, bc);
    check("ignored_start_hi", hi_out, 32'h0);
    check("ignored_start_lo", lo_out, 32'd81);
    step();
    check("ignored_start_idle", {31'd0, busy_out}, 32'h0);

    save_hi = hi_out;
    save_lo = lo_out;
    issue(MULTU, 32'd5, 32'd6);
    repeat (9) step();
    abort_in = 1'b1;
    step();
    abort_in = 1'b0;
    check("abort_busy", {31'd0, busy_out}, 32'h0);
    repeat (40) step();
    check("abort_hi", hi_out, save_hi);
    check("abort_lo", lo_out, save_lo);

    issue(DIV, 32'd1000, 32'd3);
    repeat (19) step();
    rst_n = 1'b0;
    step();
    check("midrst_hi", hi_out, 32'h0);
    check("midrst_lo", lo_out, 32'h0);
    check("midrst_busy", {31'd0, busy_out}, 32'h0);
    rst_n = 1'b1;
    step();

    run_op("b2b_first", MULTU, 32'd3, 32'd4, 32'd0, 32'd12);
    run_op("b2b_second", DIVU, 32'd50, 32'd8, 32'd2, 32'd6);

    // Abort in IDLE must not block a same-cycle start.
    abort_in = 1'b1;
    issue(MULT, 32'hFFFF_FFFE, 32'hFFFF_FFFE);
    abort_in = 1'b0;
    check("idle_abort_start_busy", {31'd0, busy_out}, 32'h1);
    wait_done(lat, bc);
    check("idle_abort_lo", lo_out, 32'd4);

    repeat (6000) begin
      start_in   = ($urandom_range(0, 2) == 0);
      op_in      = 3'($urandom_range(0, 7));
      rs_data_in = pick();
      rt_data_in = pick();
      abort_in   = ($urandom_range(0, 59) == 0);
      rst_n      = ($urandom_range(0, 799) != 0);
      step();
    end
    start_in = 1'b0;
    abort_in = 1'b0;
    rst_n = 1'b1;
    repeat (40) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Multi-cycle multiply/divide unit alongside the execute-stage ALU; owns the HI/LO register pair.
- Sequences iterative shift-add multiply and restoring divide over DATA_WIDTH cycles.
- Asserts busy_out so the hazard logic stalls the pipeline until the result is committed.
- The decode stage issues ops via a start pulse; MFHI/MFLO read hi_out/lo_out directly.

Parameters:
- DATA_WIDTH, 32, operand width; HI and LO are each DATA_WIDTH bits.
- OP_WIDTH, 3, width of the op_in command field.
- CNT_WIDTH, 6, iteration counter width; must satisfy 2^CNT_WIDTH > DATA_WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- start_in  input  1  issue strobe; sampled only in IDLE.
- op_in  input  OP_WIDTH  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, others no-op.
- rs_data_in  input  DATA_WIDTH  multiplicand / dividend / MTHI-MTLO source.
- rt_data_in  input  DATA_WIDTH  multiplier / divisor.
- abort_in  input  1  pipeline flush; cancels an in-flight op.
- hi_out  output  DATA_WIDTH  HI register.
- lo_out  output  DATA_WIDTH  LO register.
- busy_out  output  1  high in RUN and FINISH; drives the pipeline stall.
- done_out  output  1  one-cycle pulse, coincident with the HI/LO update of a MULT/DIV op.

Behaviour:
Clock and reset:
- One clock domain, clk.
- Reset is synchronous, active-low, on rst_n.
- Reset values: hi_out=0, lo_out=0, busy_out=0, done_out=0, state=IDLE, counter=0.
- Reset asserted mid-operation discards all work and reaches these values on the next edge.

FSM states: IDLE, RUN, FINISH.

IDLE:
- start_in=1 with MULT/MULTU/DIV/DIVU:
  - latch operands; for signed ops latch magnitudes (two's-complement abs) and the result signs;
  - clear the accumulator; counter=0; go to RUN.
- start_in=1 with MTHI/MTLO: write rs_data_in into HI/LO at that edge; stay in IDLE; no busy, no done.
- Any other op, or start_in=0: no effect.

RUN:
- One iteration per cycle; counter increments each cycle.
- Multiply: if the multiplier LSB is 1, add the multiplicand into the upper half of a 2*DATA_WIDTH accumulator; shift right 1.
- Divide: shift the {remainder, quotient} pair left 1; trial-subtract the divisor from the remainder; on non-negative, keep the difference and set the quotient LSB.
- After counter reaches DATA_WIDTH-1, go to FINISH.

FINISH:
- Apply sign fixup:
  - product negated if the operand signs differ;
  - quotient sign = XOR of the operand signs;
  - remainder sign = dividend sign.
- Write HI/LO: multiply HI=upper half, LO=lower half; divide HI=remainder, LO=quotient.
- Pulse done_out; go to IDLE.

Latency and handshake:
- Start accepted at edge N; RUN occupies N+1..N+DATA_WIDTH; HI/LO and done_out update at edge N+DATA_WIDTH+1.
- busy_out is high from after edge N until after edge N+DATA_WIDTH+1.
- start_in while busy_out=1 is ignored; upstream must hold the op while stalled.
- MTHI/MTLO while busy is likewise ignored.
- abort_in=1 in RUN or FINISH returns to IDLE at the next edge; HI/LO are unchanged and done_out is not pulsed.
- abort_in has priority over the FINISH write.
- abort_in in IDLE is ignored; it does not block a same-cycle start.

Boundary conditions:
- Divide by zero (DIV/DIVU, rt=0): still takes full latency; LO=all ones, HI=rs operand as issued (original signed value); no exception.
- DIV with INT_MIN / -1: LO=INT_MIN, HI=0; this falls out of the magnitude arithmetic.
- MULTU with all-ones operands: HI=0xFFFFFFFE, LO=0x00000001 (32-bit case); no overflow flag.
- Back-to-back issue: a start in the cycle immediately after done_out is accepted.

Decomposition:
- Shared package: op encodings (MULT..MTLO), FSM state encodings, DATA_WIDTH/OP_WIDTH defaults.
- Sub-module muldiv_signfix: combinational abs/negate helper, 2*DATA_WIDTH wide; reused for operand conditioning and result fixup.
- Iteration datapath and FSM stay in muldiv_sequencer.

Test Plan:
- MULT rs=7, rt=0xFFFFFFFD (-3) → done_out at edge N+33; HI=0xFFFFFFFF, LO=0xFFFFFFEB; busy_out high for exactly 33 cycles.
- DIVU rs=100, rt=7 → LO=14, HI=2. DIV rs=0xFFFFFFF9 (-7), rt=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIV rs=0x12345678, rt=0 → LO=0xFFFFFFFF, HI=0x12345678, done at N+33. DIV rs=0x80000000, rt=0xFFFFFFFF → LO=0x80000000, HI=0.
- MTHI rs=0xA5A5A5A5 in IDLE → hi_out=0xA5A5A5A5 next edge, busy_out stays 0. Second start (MULTU 2,3) at N+5 → ignored; first result committed only.
- MULTU 5*6 then abort_in at N+10 → IDLE at N+11, HI/LO hold prior values, no done_out. rst_n=0 at N+20 of a DIV → all outputs 0 next edge.
- MULTU 0xFFFFFFFF*0xFFFFFFFF → HI=0xFFFFFFFE, LO=1. Start held during done cycle and re-issued next cycle → accepted, second done at +33.
